// File: rtl/axis_bram_cmd_sched.sv
// Command scheduler for the AXIS-BRAM adapter: queues transfer descriptors,
// issues them one at a time, and tracks completion, watchdog aborts and status.
module axis_bram_cmd_sched #(
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_index,
  input  logic [ADDR_W-1:0] cmd_size,
  output logic              cntl_rw,
  output logic [ADDR_W-1:0] cntl_index,
  output logic [ADDR_W-1:0] cntl_size,
  output logic              cntl_start,
  output logic              cntl_abort,
  input  logic              bram_en,
  output logic              busy,
  output logic              done_pulse,
  output logic [CNT_W-1:0]  done_cnt,
  output logic              err_range,
  output logic              err_timeout,
  input  logic              status_clr,
  output logic              irq,
  output logic [2:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ABORT} state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] size;
  } desc_t;

  state_t            state;
  desc_t             mem [DEPTH];
  desc_t             head;
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W:0]   beat_cnt;
  logic [WD_W-1:0]   wd;

  // Handshake: a descriptor moves when cmd_valid & cmd_ready are both high at a
  // rising edge; cmd_ready depends only on registered FIFO state, never on cmd_valid.
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr[PTR_W-1:0]];

  assign busy      = (state == LOAD) || (state == RUN);
  assign irq       = (done_cnt != '0) || err_range || err_timeout;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= '{rw: cmd_rw, index: cmd_index, size: cmd_size};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cntl_rw     <= 1'b0;
      cntl_index  <= '0;
      cntl_size   <= '0;
      cntl_start  <= 1'b0;
      cntl_abort  <= 1'b0;
      done_pulse  <= 1'b0;
      done_cnt    <= '0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      beat_cnt    <= '0;
      wd          <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cntl_start <= 1'b0;
      cntl_abort <= 1'b0;
      done_pulse <= 1'b0;
      // Clear first so that a same-cycle error or completion below still lands.
      if (status_clr) begin
        done_cnt    <= '0;
        err_range   <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            cntl_rw    <= head.rw;
            cntl_index <= head.index;
            cntl_size  <= head.size;
            if (head.size < head.index) begin
              err_range <= 1'b1;
            end else begin
              state      <= LOAD;
              cntl_start <= 1'b1;
            end
          end
        end
        LOAD: begin
          beat_cnt <= {1'b0, cntl_size} - {1'b0, cntl_index} + 1'b1;
          wd       <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (bram_en) begin
            beat_cnt <= beat_cnt - 1'b1;
            wd       <= '0;
            if (beat_cnt == (ADDR_W+1)'(1)) begin
              state      <= DONE;
              done_pulse <= 1'b1;
            end
          end else if (wd == WD_LAST) begin
            state      <= ABORT;
            cntl_abort <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (status_clr)              done_cnt <= CNT_W'(1);
          else if (done_cnt != CNT_MAX) done_cnt <= done_cnt + 1'b1;
        end
        ABORT: begin
          state       <= IDLE;
          err_timeout <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bram_cmd_sched.sv
// Self-checking bench for axis_bram_cmd_sched: descriptor scoreboard on cntl_start,
// directed checks for latency, backpressure, range drop, watchdog, status and reset.
module tb_axis_bram_cmd_sched;

  localparam int ADDR_W  = 9;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int DW      = 1 + 2*ADDR_W;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_rw = 1'b0;
  logic [ADDR_W-1:0] cmd_index = '0;
  logic [ADDR_W-1:0] cmd_size = '0;
  logic              cntl_rw;
  logic [ADDR_W-1:0] cntl_index;
  logic [ADDR_W-1:0] cntl_size;
  logic              cntl_start;
  logic              cntl_abort;
  logic              bram_en = 1'b0;
  logic              busy;
  logic              done_pulse;
  logic [CNT_W-1:0]  done_cnt;
  logic              err_range;
  logic              err_timeout;
  logic              status_clr = 1'b0;
  logic              irq;
  logic [2:0]        dbg_state;

  axis_bram_cmd_sched #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_index(cmd_index), .cmd_size(cmd_size),
    .cntl_rw(cntl_rw), .cntl_index(cntl_index), .cntl_size(cntl_size),
    .cntl_start(cntl_start), .cntl_abort(cntl_abort),
    .bram_en(bram_en), .busy(busy), .done_pulse(done_pulse), .done_cnt(done_cnt),
    .err_range(err_range), .err_timeout(err_timeout), .status_clr(status_clr),
    .irq(irq), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int exp_done = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every cntl_start must carry the oldest accepted, in-range descriptor
  logic [DW-1:0] mon_exp;
  always @(negedge clk) begin
    if (rstn && cntl_start) begin
      n_start++;
      if (exp_q.size() == 0) begin
        check("start_unexpected", 32'(cntl_start), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("start_desc", 32'({cntl_rw, cntl_index, cntl_size}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic rw, input logic [ADDR_W-1:0] idx, input logic [ADDR_W-1:0] sz);
    int g = 0;
    while (!cmd_ready && g < 200) begin tick(); g++; end
    check("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_index = idx;
    cmd_size  = sz;
    if (sz >= idx) exp_q.push_back({rw, idx, sz});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_run();
    int g = 0;
    while (dbg_state != S_RUN && g < 100) begin tick(); g++; end
    check("wait_run", 32'(dbg_state), 32'(S_RUN));
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      bram_en = 1'b1;
      tick();
    end
    bram_en = 1'b0;
  endtask

  task automatic bump_done();
    exp_done = (exp_done < CNT_SAT) ? exp_done + 1 : CNT_SAT;
  endtask

  // beats until one before the end, confirm no early completion, then the final beat
  task automatic finish_run(input int n);
    wait_run();
    beats(n - 1);
    check("no_early_done", 32'(done_pulse), 32'd0);
    beats(1);
    check("done_pulse", 32'(done_pulse), 32'd1);
    bump_done();
  endtask

  task automatic run_one(input logic rw, input logic [ADDR_W-1:0] idx, input logic [ADDR_W-1:0] sz);
    push_cmd(rw, idx, sz);
    finish_run(int'(sz) - int'(idx) + 1);
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
  endtask

  int c;
  int s;

  initial begin
    tick(); tick();
    rstn = 1'b1;
    tick();

    // reset state
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_errs", 32'({err_range, err_timeout}), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cntl", 32'({cntl_rw, cntl_index, cntl_size, cntl_start, cntl_abort}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // 1: latency, LOAD-cycle beat ignored, 16-beat completion
    push_cmd(1'b1, 9'd0, 9'd15);
    check("t1_no_start_yet", 32'(cntl_start), 32'd0);
    tick();
    check("t1_start", 32'(cntl_start), 32'd1);
    check("t1_state_load", 32'(dbg_state), 32'(S_LOAD));
    check("t1_busy", 32'(busy), 32'd1);
    bram_en = 1'b1;
    tick();
    bram_en = 1'b0;
    beats(15);
    check("t1_no_early_done", 32'(done_pulse), 32'd0);
    beats(1);
    check("t1_done_pulse", 32'(done_pulse), 32'd1);
    bump_done();
    tick();
    check("t1_done_cnt", 32'(done_cnt), 32'(exp_done));
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_not_busy", 32'(busy), 32'd0);

    // bram_en while IDLE has no effect
    beats(4);
    check("idle_beats_cnt", 32'(done_cnt), 32'(exp_done));
    check("idle_beats_busy", 32'(busy), 32'd0);

    pulse_clr();
    exp_done = 0;
    check("clr_cnt", 32'(done_cnt), 32'd0);
    check("clr_irq", 32'(irq), 32'd0);

    // 2: five back-to-back pushes fill the FIFO behind the running transfer
    for (int i = 0; i < 5; i++) push_cmd(i[0], ADDR_W'(i*8), ADDR_W'(i*9));
    check("t2_ready_full", 32'(cmd_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) finish_run(i + 1);
    tick();
    check("t2_done_cnt", 32'(done_cnt), 32'(exp_done));
    check("t2_q_drained", 32'(exp_q.size()), 32'd0);

    // 3: size < index is dropped, next descriptor runs
    push_cmd(1'b0, 9'd20, 9'd10);
    push_cmd(1'b1, 9'd3, 9'd3);
    wait_run();
    check("t3_err_range", 32'(err_range), 32'd1);
    beats(1);
    check("t3_done_pulse", 32'(done_pulse), 32'd1);
    bump_done();
    tick();
    check("t3_done_cnt", 32'(done_cnt), 32'(exp_done));
    check("t3_no_timeout", 32'(err_timeout), 32'd0);

    // 4: watchdog abort 16 cycles after the last beat, next command then runs
    push_cmd(1'b0, 9'd0, 9'd7);
    push_cmd(1'b1, 9'd5, 9'd6);
    wait_run();
    beats(3);
    c = 1;
    while (!cntl_abort && c < 40) begin tick(); c++; end
    check("t4_abort_delay", 32'(c), 32'd16);
    check("t4_state_abort", 32'(dbg_state), 32'(S_ABORT));
    check("t4_abort_not_busy", 32'(busy), 32'd0);
    tick();
    check("t4_abort_one_cycle", 32'(cntl_abort), 32'd0);
    check("t4_err_timeout", 32'(err_timeout), 32'd1);
    check("t4_done_cnt_kept", 32'(done_cnt), 32'(exp_done));
    finish_run(2);
    tick();
    check("t4_next_done_cnt", 32'(done_cnt), 32'(exp_done));

    // 5: status_clr vs same-cycle completion and same-cycle error
    pulse_clr();
    exp_done = 0;
    check("t5_clr_all", 32'({done_cnt, err_range, err_timeout}), 32'd0);
    for (int i = 0; i < 3; i++) run_one(1'b0, ADDR_W'(i), ADDR_W'(i));
    tick();
    check("t5_cnt3", 32'(done_cnt), 32'd3);
    push_cmd(1'b1, 9'd7, 9'd7);
    wait_run();
    beats(1);
    check("t5_done_pulse", 32'(done_pulse), 32'd1);
    pulse_clr();
    exp_done = 1;
    check("t5_clr_with_done", 32'(done_cnt), 32'(exp_done));
    pulse_clr();
    exp_done = 0;
    check("t5_clr_alone", 32'(done_cnt), 32'd0);
    check("t5_irq_low", 32'(irq), 32'd0);
    push_cmd(1'b0, 9'd9, 9'd2);
    pulse_clr();
    check("t5_err_survives_clr", 32'(err_range), 32'd1);
    check("t5_irq_err", 32'(irq), 32'd1);
    pulse_clr();
    check("t5_err_cleared", 32'(err_range), 32'd0);

    // done_cnt saturation
    for (int i = 0; i < CNT_SAT + 2; i++) run_one(1'b1, ADDR_W'(i), ADDR_W'(i));
    tick();
    check("sat_done_cnt", 32'(done_cnt), 32'(CNT_SAT));

    // full-range 512-beat transfer
    run_one(1'b0, 9'd0, 9'd511);
    check("full_size_reg", 32'(cntl_size), 32'd511);
    tick();
    check("full_done_cnt", 32'(done_cnt), 32'(exp_done));

    // 6: asynchronous reset mid-RUN with two queued
    push_cmd(1'b1, 9'd0, 9'd4);
    push_cmd(1'b0, 9'd1, 9'd2);
    push_cmd(1'b1, 9'd2, 9'd3);
    wait_run();
    beats(2);
    check("t6_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("t6_async_busy", 32'(busy), 32'd0);
    tick();
    rstn = 1'b1;
    exp_q.delete();
    exp_done = 0;
    check("t6_ready", 32'(cmd_ready), 32'd1);
    check("t6_status", 32'({done_cnt, err_range, err_timeout, irq}), 32'd0);
    check("t6_pulses", 32'({cntl_start, cntl_abort, done_pulse}), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(S_IDLE));
    s = n_start;
    for (int i = 0; i < 20; i++) tick();
    check("t6_no_start", 32'(n_start), 32'(s));
    run_one(1'b1, 9'd100, 9'd102);
    tick();
    check("t6_after_reset_cnt", 32'(done_cnt), 32'(exp_done));

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
